mult_share_arbiter: RTL and testbench

- Shares one sequential Booth multiplier (load/done handshake, N-bit signed operands, 2N-bit product) between NREQ requesters.
- Arbitrates round-robin, captures the winner's operands and drives the multiplier's load.
- Holds the operands stable through the multiplier's operand-sampling cycle, waits for done, then returns the product to the granted requester.
- Sits between the requester blocks and the single multiplier instance.

---
 rtl/mult_share_arbiter_if.sv | 29 ++
 rtl/mult_share_arbiter.sv | 122 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared Booth multiplier arbiter.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface mult_share_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*N-1:0]    rsp_data;
    logic              busy;
    logic              m_load;
    logic [N-1:0]      m_a;
    logic [N-1:0]      m_b;
    logic              m_done;
    logic [2*N-1:0]    m_c;

    modport slave (
        input  req, req_a, req_b, m_done, m_c,
        output gnt, rsp_valid, rsp_data, busy, m_load, m_a, m_b
    );

    modport master (
        output req, req_a, req_b, m_done, m_c,
        input  gnt, rsp_valid, rsp_data, busy, m_load, m_a, m_b
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among NREQ requesters.
// Operands stay latched on m_a/m_b until the multiplier reports done.
module mult_share_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_share_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rsp_valid;
    logic [2*N-1:0]  r_rsp_data;
    logic            r_busy;
    logic            r_m_load;
    logic [N-1:0]    r_m_a;
    logic [N-1:0]    r_m_b;

    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_win;
    logic            w_found;
    logic [IW-1:0]   w_ptr_nx;
    logic [NREQ-1:0] w_gnt_nx;
    logic [NREQ-1:0] w_rsp_valid_nx;
    logic            w_busy_nx;
    logic            w_load_nx;
    logic            w_cap;
    logic            w_rsp;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = IW'((32'(r_ptr) + 32'(i)) % 32'(NREQ));
            if (bus.req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_ptr_nx = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_state_nx     = r_state;
        w_gnt_nx       = '0;
        w_rsp_valid_nx = '0;
        w_busy_nx      = r_busy;
        w_load_nx      = 1'b0;
        w_cap          = 1'b0;
        w_rsp          = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy_nx = 1'b0;
                if (w_found) begin
                    w_cap      = 1'b1;
                    w_gnt_nx   = NREQ'(1) << w_win;
                    w_load_nx  = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: w_state_nx = WAIT;
            WAIT: begin
                if (bus.m_done) begin
                    w_rsp          = 1'b1;
                    w_rsp_valid_nx = NREQ'(1) << r_owner;
                    w_state_nx     = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_m_load    <= 1'b0;
            r_m_a       <= '0;
            r_m_b       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_gnt       <= w_gnt_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_busy      <= w_busy_nx;
            r_m_load    <= w_load_nx;
            if (w_cap) begin
                r_m_a   <= bus.req_a[w_win*N +: N];
                r_m_b   <= bus.req_b[w_win*N +: N];
                r_owner <= w_win;
                r_ptr   <= w_ptr_nx;
            end
            if (w_rsp) begin
                r_rsp_data <= bus.m_c;
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    assign bus.m_load    = r_m_load;
    assign bus.m_a       = r_m_a;
    assign bus.m_b       = r_m_b;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter with a cycle-timed Booth multiplier model.
// Directed vectors plus multi-requester, hold-over and mid-operation reset sequences.
module tb_mult_share_arbiter;
    localparam int N    = 8;
    localparam int NREQ = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    mult_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus();

    mult_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier timing: load seen, one INIT cycle sampling operands,
    // then done in c(2N+4+k) where c1 is the load cycle.
    function automatic int booth_k(input logic [N-1:0] b);
        int   k;
        logic prev;
        k    = 0;
        prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (b[i] != prev) k++;
            prev = b[i];
        end
        return k;
    endfunction

    function automatic logic [2*N-1:0] smul(input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [2*N-1:0] sa;
        logic [2*N-1:0] sb;
        sa = {{N{a[N-1]}}, a};
        sb = {{N{b[N-1]}}, b};
        return sa * sb;
    endfunction

    int             mst;
    int             mcnt;
    logic [2*N-1:0] mprod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst         <= 0;
            mcnt        <= 0;
            mprod       <= '0;
            bus.m_done  <= 1'b0;
            bus.m_c     <= '0;
        end else begin
            bus.m_done <= 1'b0;
            if (mst == 0 && bus.m_load) begin
                mst <= 1;
            end else if (mst == 1) begin
                mst   <= 2;
                mcnt  <= 2 * N + 1 + booth_k(bus.m_b);
                mprod <= smul(bus.m_a, bus.m_b);
            end else if (mst == 2) begin
                if (mcnt == 1) begin
                    bus.m_done <= 1'b1;
                    bus.m_c    <= mprod;
                    mst        <= 0;
                end
                mcnt <= mcnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.gnt == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.rsp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_one(input int idx, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic [2*N-1:0] p,
                           input int lat);
        int t0;
        @(negedge clk);
        bus.req_a[idx*N +: N] = a;
        bus.req_b[idx*N +: N] = b;
        bus.req[idx]          = 1'b1;
        t0 = cyc;
        @(negedge clk);
        chk("gnt", 64'(bus.gnt), 64'(1 << idx));
        chk("m_load", 64'(bus.m_load), 64'd1);
        chk("m_a", 64'(bus.m_a), 64'(a));
        chk("m_b", 64'(bus.m_b), 64'(b));
        chk("busy_c1", 64'(bus.busy), 64'd1);
        bus.req[idx] = 1'b0;
        wait_rsp();
        chk("rsp_cycle", 64'(cyc - t0), 64'(lat));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(1 << idx));
        chk("rsp_data", 64'(bus.rsp_data), 64'(p));
        chk("busy_rsp", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("busy_after", 64'(bus.busy), 64'd0);
        chk("rsp_clear", 64'(bus.rsp_valid), 64'd0);
    endtask

    typedef struct {
        int             idx;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
        int             lat;
    } vec_t;

    vec_t tv[5];

    logic [N-1:0]   qa[4];
    logic [N-1:0]   qb[4];
    logic [2*N-1:0] qp[4];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int last;
        int seen;

        tv[0] = '{0, 8'd5,   8'h00, 16'h0000, 21};
        tv[1] = '{1, 8'd3,   8'hFE, 16'hFFFA, 22};
        tv[2] = '{1, 8'hF9,  8'd9,  16'hFFC1, 25};
        tv[3] = '{2, 8'h80,  8'h80, 16'h4000, 22};
        tv[4] = '{3, 8'h7F,  8'h55, 16'h2A2B, 29};

        qa = '{8'd3,  8'hFC, 8'd10, 8'hFF};
        qb = '{8'd7,  8'd5,  8'hFA, 8'hFF};
        qp = '{16'h0015, 16'hFFEC, 16'hFFC4, 16'h0001};

        cyc       = 0;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_m_load", 64'(bus.m_load), 64'd0);
        chk("rst_m_a", 64'(bus.m_a), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_one(tv[i].idx, tv[i].a, tv[i].b, tv[i].p, tv[i].lat);
        end

        // All four at ptr=0: served 0..3, each gnt right after previous rsp.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*N +: N] = qa[i];
            bus.req_b[i*N +: N] = qb[i];
        end
        bus.req = 4'hF;
        t0      = cyc;
        last    = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt();
            chk("rr_gnt", 64'(bus.gnt), 64'(1 << i));
            if (i == 0) chk("rr_first", 64'(cyc - t0), 64'd1);
            else        chk("rr_b2b", 64'(cyc - last), 64'd1);
            bus.req[i] = 1'b0;
            wait_rsp();
            chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'(1 << i));
            chk("rr_rsp_data", 64'(bus.rsp_data), 64'(qp[i]));
            last = cyc;
        end
        @(negedge clk);
        chk("rr_idle", 64'(bus.busy), 64'd0);

        // Move ptr to 2, then hold req[2] through its response.
        run_one(1, 8'd2, 8'd2, 16'h0004, 23);
        @(negedge clk);
        bus.req_a[2*N +: N] = 8'd5;
        bus.req_b[2*N +: N] = 8'd3;
        bus.req_a[3*N +: N] = 8'hFE;
        bus.req_b[3*N +: N] = 8'd4;
        bus.req             = 4'b1100;
        wait_gnt();
        chk("hold_gnt2", 64'(bus.gnt), 64'h4);
        wait_rsp();
        chk("hold_rsp2", 64'(bus.rsp_valid), 64'h4);
        chk("hold_data2", 64'(bus.rsp_data), 64'h000F);
        @(negedge clk);
        chk("hold_gnt3", 64'(bus.gnt), 64'h8);
        bus.req[3] = 1'b0;
        wait_rsp();
        chk("hold_rsp3", 64'(bus.rsp_valid), 64'h8);
        chk("hold_data3", 64'(bus.rsp_data), 64'hFFF8);
        @(negedge clk);
        chk("hold_regnt2", 64'(bus.gnt), 64'h4);
        bus.req[2] = 1'b0;
        wait_rsp();
        chk("hold_rsp2b", 64'(bus.rsp_valid), 64'h4);
        chk("hold_data2b", 64'(bus.rsp_data), 64'h000F);
        @(negedge clk);

        // Reset in the middle of WAIT.
        @(negedge clk);
        bus.req_a[0 +: N] = 8'd6;
        bus.req_b[0 +: N] = 8'd7;
        bus.req[0]        = 1'b1;
        wait_gnt();
        chk("mid_gnt", 64'(bus.gnt), 64'h1);
        bus.req[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(bus.gnt), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_m_load", 64'(bus.m_load), 64'd0);
        chk("mid_rst_m_a", 64'(bus.m_a), 64'd0);
        chk("mid_rst_m_b", 64'(bus.m_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid != '0 || bus.gnt != '0 || bus.busy) seen++;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);
        run_one(2, 8'd6, 8'd7, 16'h002A, 23);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
